rxd_barker_sync: RTL



---
 rtl/rxd_barker_sync_if.sv | 32 +++
 rtl/rxd_barker_sync.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/rxd_barker_sync_if.sv
// Chip-in / symbol-out bundle of the Barker-13 despreader.
// master: the chip source + bit sink side; slave: the despreader itself.
// Carries no clock; clk_sig and rst_n stay plain ports on the block.
interface rxd_barker_sync_if;
  logic       chip_en;     // chip strobe, one cycle per chip
  logic       rxd_chip;    // hard-decision chip, valid with chip_en
  logic       data_bit;    // despread bit, valid with data_valid
  logic       data_valid;  // one-cycle pulse per decided symbol
  logic       lock;        // high while symbol timing is held
  logic       miss;        // decided symbol was below threshold
  logic [4:0] corr_out;    // signed correlation of the decided symbol

  modport master (
    output chip_en,
    output rxd_chip,
    input  data_bit,
    input  data_valid,
    input  lock,
    input  miss,
    input  corr_out
  );

  modport slave (
    input  chip_en,
    input  rxd_chip,
    output data_bit,
    output data_valid,
    output lock,
    output miss,
    output corr_out
  );
endinterface

// File: rtl/rxd_barker_sync.sv
// Barker-13 sliding correlator; acquires symbol timing on a peak, then emits one bit per 13 chips.
// Latency: data_valid two clk_sig cycles after the strobe of the chip that completes a symbol.
// Backpressure: none; every chip_en is consumed, outputs are unacknowledged pulses.
module rxd_barker_sync #(
  parameter int unsigned THRESH   = 11,  // minimum |corr| for a valid peak
  parameter int unsigned MISS_MAX = 3    // consecutive weak symbols that drop lock
) (
  input  logic             clk_sig,
  input  logic             rst_n,
  rxd_barker_sync_if.slave bus
);

  // Oldest chip sits in bit 12 and lines up with the first transmitted chip.
  localparam logic [12:0] PATTERN    = 13'b1111100110101;
  localparam logic [4:0]  THRESH_W   = 5'(THRESH);
  localparam logic [3:0]  MISS_MAX_W = 4'(MISS_MAX);
  localparam logic [3:0]  LAST_CHIP  = 4'd12;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCK   = 1'b1
  } state_e;

  // Chip history and evaluation strobe
  logic [12:0] sr_q;
  logic [12:0] sr_d;
  logic        eval_q;

  // Timing state
  state_e      state_q;
  logic [3:0]  chip_cnt_q;
  logic [3:0]  miss_cnt_q;
  logic [3:0]  miss_cnt_d;

  // Registered outputs
  logic        data_bit_q;
  logic        data_valid_q;
  logic        lock_q;
  logic        miss_q;
  logic [4:0]  corr_q;

  // Correlator results for the current window
  logic [12:0] diff;
  logic [3:0]  mism;
  logic [4:0]  corr;
  logic [4:0]  corr_abs;
  logic        peak;
  logic        sym_bit;

  assign sr_d = {sr_q[11:0], bus.rxd_chip};

  // Shift a chip in on each strobe; eval_q marks the cycle the new window is visible.
  always_ff @(posedge clk_sig or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= '0;
      eval_q <= 1'b0;
    end else begin
      eval_q <= bus.chip_en;
      if (bus.chip_en) begin
        sr_q <= sr_d;
      end
    end
  end

  // Correlation = agreements - disagreements = 13 - 2*mismatches; odd, never zero.
  always_comb begin
    diff = sr_q ^ PATTERN;
    mism = '0;
    for (int i = 0; i < 13; i++) begin
      mism = mism + {3'b000, diff[i]};
    end
    // Modulo-32 subtraction yields the two's-complement value directly.
    corr     = 5'd13 - {mism, 1'b0};
    corr_abs = corr[4] ? (~corr + 5'd1) : corr;
    peak     = (corr_abs >= THRESH_W);
    // corr is never zero, so the sign bit alone decides the data bit.
    sym_bit  = ~corr[4];
  end

  assign miss_cnt_d = miss_cnt_q + 4'd1;

  // Search/lock sequencing with registered outputs; only acts on the eval strobe.
  always_ff @(posedge clk_sig or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SEARCH;
      chip_cnt_q   <= '0;
      miss_cnt_q   <= '0;
      data_bit_q   <= 1'b0;
      data_valid_q <= 1'b0;
      lock_q       <= 1'b0;
      miss_q       <= 1'b0;
      corr_q       <= '0;
    end else begin
      data_valid_q <= 1'b0;
      if (eval_q) begin
        case (state_q)
          SEARCH: begin
            // Any window may start a symbol while searching.
            if (peak) begin
              data_valid_q <= 1'b1;
              data_bit_q   <= sym_bit;
              miss_q       <= 1'b0;
              corr_q       <= corr;
              lock_q       <= 1'b1;
              chip_cnt_q   <= '0;
              miss_cnt_q   <= '0;
              state_q      <= LOCK;
            end
          end
          LOCK: begin
            if (chip_cnt_q != LAST_CHIP) begin
              // Mid-symbol windows are ignored; timing is not re-trained while locked.
              chip_cnt_q <= chip_cnt_q + 4'd1;
            end else begin
              chip_cnt_q <= '0;
              if (peak) begin
                data_valid_q <= 1'b1;
                data_bit_q   <= sym_bit;
                miss_q       <= 1'b0;
                corr_q       <= corr;
                miss_cnt_q   <= '0;
              end else if (miss_cnt_d < MISS_MAX_W) begin
                // Weak symbol: still decided by sign, but flagged.
                data_valid_q <= 1'b1;
                data_bit_q   <= sym_bit;
                miss_q       <= 1'b1;
                corr_q       <= corr;
                miss_cnt_q   <= miss_cnt_d;
              end else begin
                // Too many weak symbols in a row: timing is presumed lost.
                lock_q     <= 1'b0;
                miss_cnt_q <= '0;
                state_q    <= SEARCH;
              end
            end
          end
          default: begin
            state_q <= SEARCH;
          end
        endcase
      end
    end
  end

  assign bus.data_bit   = data_bit_q;
  assign bus.data_valid = data_valid_q;
  assign bus.lock       = lock_q;
  assign bus.miss       = miss_q;
  assign bus.corr_out   = corr_q;

endmodule
